event_ts_arbiter: RTL and testbench
===================================

Name: event_ts_arbiter

Overview:
- Shares the free-running wall-clock timestamp among NUM_REQ pixel-group requesters.
- Round-robin arbitrates pending event requests and latches the current timestamp for the winner.
- Presents {requester id, timestamp} on a valid/ready output toward the next hierarchy level.
- Sits between the pixel-group event logic and the upper-level event FIFO; the timestamp source is the shared wall-clock counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- SIZE, 32, timestamp width, equal to the package constant SIZE.
- ID_W, $clog2(NUM_REQ), requester id width (derived; not overridden).

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous, active-low reset.
- enable_i  input  1  grant enable; when low, no new grant is issued.
- timestamp_i  input  SIZE  wall-clock timestamp.
- req_i  input  NUM_REQ  per-requester event request (level, held until ack).
- ack_o  output  NUM_REQ  one-cycle grant acknowledge, one-hot or zero.
- evt_valid_o  output  1  output event valid.
- evt_ready_i  input  1  downstream ready.
- evt_id_o  output  ID_W  granted requester index.
- evt_ts_o  output  SIZE  timestamp captured at grant.
- ts_wrap_o  output  1  one-cycle pulse when timestamp_i wraps.
- busy_o  output  1  high while in SEND.

Behaviour:
- Reset (reset_i==0 at a clk_i edge):
  - state=IDLE; ack_o=0, evt_valid_o=0, evt_id_o=0, evt_ts_o=0, ts_wrap_o=0, busy_o=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - Reset overrides everything, including a pending SEND; the in-flight event is discarded.
- FSM states: IDLE, SEND.
- Arbitration term: `arb = enable_i & |(req_i & ~ack_o)`. Masking with ack_o prevents regranting a requester in the cycle it is being acked.
- Winner: the first set bit of (req_i & ~ack_o), searching upward from pointer+1 modulo NUM_REQ.
- IDLE:
  - If arb at cycle t, go to SEND at t+1.
  - At t+1: evt_valid_o=1, evt_id_o=winner, evt_ts_o=timestamp_i sampled at t, ack_o[winner]=1 for that cycle only, pointer=winner.
  - Otherwise stay in IDLE with all outputs idle.
- SEND:
  - evt_valid_o=1; evt_id_o and evt_ts_o held stable until handshake (evt_valid_o & evt_ready_i).
  - Handshake with arb: issue the next grant back-to-back, same timing as from IDLE. Sustained throughput is 1 event/cycle.
  - Handshake without arb: return to IDLE, evt_valid_o=0 next cycle.
  - No handshake: stay in SEND; ack_o=0; req_i changes are ignored.
- Latency: request to valid/ack is 1 cycle.
- Requesters must deassert req on the cycle after seeing ack. A request still high 2 cycles after its ack is a new event.
- enable_i low:
  - Blocks new grants only.
  - An event already in SEND still completes normally.
- Wrap detection:
  - Register the previous timestamp_i; ts_wrap_o=1 for one cycle when timestamp_i < previous.
  - Suppressed in the first cycle after reset.
  - Independent of the FSM.
- Width rules:
  - Timestamp is copied unmodified; no arithmetic is applied to it.
  - Pointer arithmetic is modulo NUM_REQ, including non-power-of-2 values.
- Fairness: with all requesters continuously requesting and ready=1, each is granted once every NUM_REQ events.
- busy_o = (state==SEND).

Decomposition:
- lib_arbiter_pkg holds:
  - SIZE and NUM_REQ defaults.
  - typedef enum logic {IDLE, SEND} evt_arb_state_t.
  - typedef struct packed {id, ts} evt_pkt_t.
- One sub-module: rr_pick, combinational. Inputs req vector, pointer, and enable. Outputs grant_valid and grant_idx.
- Wrap detect, FSM, and output registers stay in event_ts_arbiter.

Test Plan:
- Reset then single request: timestamp_i=100 and req_i=0001 at cycle t → at t+1 evt_valid_o=1, evt_id_o=0, evt_ts_o=100, ack_o=0001; with ready=1, valid drops at t+2.
- Round-robin fairness: req_i=1111 held, each requester drops its req after ack then re-raises it, ready=1 → ids 0,1,2,3,0,1… on consecutive cycles, one event per cycle, no duplicate ack.
- Backpressure: evt_ready_i=0 for 5 cycles with req_i=0110 → id 1 and its ts held stable for 5 cycles, no further ack; ready=1 → id 2 granted on the next cycle.
- enable_i low: enable_i=0 with req_i=1000 → no ack and valid stays 0; enable_i=1 → grant id 3 one cycle later. Also drop enable_i during SEND → the current event still completes.
- Timestamp wrap: timestamp_i steps FFFFFFFE, FFFFFFFF, 00000000 → ts_wrap_o pulses exactly once in the cycle that 0 is presented.
- Reset mid-SEND: reset_i=0 with valid=1 and ready=0 → the next cycle has valid=0 and pointer reset; req_i=1111 afterwards → id 0 granted first.

Source files
------------

// File: rtl/lib_arbiter_pkg.sv
// Shared types and defaults for the event timestamp arbiter.
package lib_arbiter_pkg;

    localparam int SIZE     = 32;
    localparam int NUM_REQ  = 4;
    localparam int EVT_ID_W = $clog2(NUM_REQ);
    localparam int EVT_TS_W = SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } evt_arb_state_t;

    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic [EVT_TS_W-1:0] ts;
    } evt_pkt_t;

endpackage

// File: rtl/event_ts_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above the pointer, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_idx
);

    // Scan ptr+1 .. ptr+NUM_REQ; the modulo keeps non-power-of-2 counts correct.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!grant_valid && en && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/event_ts_arbiter.sv
// Round-robin event arbiter that stamps each grant with the shared wall-clock timestamp
// and presents {id, ts} on a valid/ready port.
module event_ts_arbiter #(
    parameter int NUM_REQ = lib_arbiter_pkg::NUM_REQ,
    parameter int SIZE    = lib_arbiter_pkg::SIZE,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [SIZE-1:0]    timestamp_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [ID_W-1:0]    evt_id_o,
    output logic [SIZE-1:0]    evt_ts_o,
    output logic               ts_wrap_o,
    output logic               busy_o
);
    import lib_arbiter_pkg::*;

    evt_arb_state_t     state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    evt_pkt_t           pkt_q, pkt_d;
    logic [SIZE-1:0]    ts_prev_q, ts_prev_d;
    logic               prev_vld_q, prev_vld_d;

    logic               grant_valid;
    logic [ID_W-1:0]    grant_idx;
    logic               handshake;

    // A requester being acked this cycle is masked so it cannot be granted twice.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req         (req_i & ~ack_q),
        .ptr         (ptr_q),
        .en          (enable_i),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign handshake = (state_q == SEND) && evt_ready_i;

    // Next-state and output-register values for the grant FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        pkt_d   = pkt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d  = SEND;
                    ptr_d    = grant_idx;
                    ack_d    = NUM_REQ'(1) << grant_idx;
                    pkt_d.id = EVT_ID_W'(grant_idx);
                    pkt_d.ts = EVT_TS_W'(timestamp_i);
                end
            end
            SEND: begin
                if (handshake) begin
                    if (grant_valid) begin
                        ptr_d    = grant_idx;
                        ack_d    = NUM_REQ'(1) << grant_idx;
                        pkt_d.id = EVT_ID_W'(grant_idx);
                        pkt_d.ts = EVT_TS_W'(timestamp_i);
                    end else begin
                        state_d = IDLE;
                        pkt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, pointer, ack pulse and held event; reset discards any in-flight event.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            ack_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            pkt_q   <= pkt_d;
        end
    end

    // Previous-timestamp tracking for wrap detection.
    always_comb begin
        ts_prev_d  = timestamp_i;
        prev_vld_d = 1'b1;
    end

    // The valid flag suppresses a false wrap in the first cycle after reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            prev_vld_q <= 1'b0;
        end else begin
            prev_vld_q <= prev_vld_d;
        end
    end

    // Previous timestamp is plain data; it needs no reset because prev_vld_q gates it.
    always_ff @(posedge clk_i) begin
        ts_prev_q <= ts_prev_d;
    end

    assign ts_wrap_o   = prev_vld_q && (timestamp_i < ts_prev_q);
    assign ack_o       = ack_q;
    assign evt_valid_o = (state_q == SEND);
    assign busy_o      = (state_q == SEND);
    assign evt_id_o    = ID_W'(pkt_q.id);
    assign evt_ts_o    = SIZE'(pkt_q.ts);

endmodule

// File: tb/tb_event_ts_arbiter.sv
// Self-checking bench for event_ts_arbiter with an expected-event scoreboard.
module tb_event_ts_arbiter;

    logic        clk;
    logic        reset_i;
    logic        enable_i;
    logic [31:0] timestamp_i;
    logic [3:0]  req_i;
    logic [3:0]  ack_o;
    logic        evt_valid_o;
    logic        evt_ready_i;
    logic [1:0]  evt_id_o;
    logic [31:0] evt_ts_o;
    logic        ts_wrap_o;
    logic        busy_o;

    typedef struct {
        int          id;
        logic [31:0] ts;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    event_ts_arbiter #(.NUM_REQ(4), .SIZE(32)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .timestamp_i (timestamp_i),
        .req_i       (req_i),
        .ack_o       (ack_o),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_id_o    (evt_id_o),
        .evt_ts_o    (evt_ts_o),
        .ts_wrap_o   (ts_wrap_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_i = 1'b0; enable_i = 1'b1; evt_ready_i = 1'b1;
        req_i = 4'b0000; timestamp_i = 32'd50;
        tick; tick;
        total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", evt_valid_o); end
        total++; if (ack_o !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", ack_o); end
        total++; if (evt_id_o !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", evt_id_o); end
        total++; if (evt_ts_o !== 32'd0) begin bad++; $display("FAIL reset_ts got=%0h want=0", evt_ts_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        // first cycle after reset: timestamp lower than the one seen in reset must not flag a wrap
        reset_i = 1'b1; timestamp_i = 32'd0;
        #1;
        total++; if (ts_wrap_o !== 1'b0) begin bad++; $display("FAIL reset_wrap_suppress got=%b want=0", ts_wrap_o); end
        tick;
    endtask

    task automatic test_single;
        timestamp_i = 32'd100; req_i = 4'b0001;
        sb.push_back('{0, 32'd100});
        tick;
        e = sb.pop_front();
        total++; if (evt_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", evt_valid_o); end
        total++; if (ack_o !== (4'b0001 << e.id)) begin bad++; $display("FAIL single_ack got=%b want=0001", ack_o); end
        total++; if (evt_id_o !== 2'(e.id)) begin bad++; $display("FAIL single_id got=%0d want=%0d", evt_id_o, e.id); end
        total++; if (evt_ts_o !== e.ts) begin bad++; $display("FAIL single_ts got=%0d want=%0d", evt_ts_o, e.ts); end
        req_i = 4'b0000; timestamp_i = 32'd101;
        tick;
        total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL single_drop got=%b want=0", evt_valid_o); end
    endtask

    task automatic test_fairness;
        logic [3:0] prev_ack;
        reset_i = 1'b0; tick; reset_i = 1'b1;
        prev_ack = 4'b0000;
        req_i = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            timestamp_i = 32'd1000 + 32'(k);
            sb.push_back('{k % 4, timestamp_i});
            tick;
            e = sb.pop_front();
            total++; if (evt_valid_o !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b want=1", k, evt_valid_o); end
            total++; if (evt_id_o !== 2'(e.id)) begin bad++; $display("FAIL rr_id[%0d] got=%0d want=%0d", k, evt_id_o, e.id); end
            total++; if (evt_ts_o !== e.ts) begin bad++; $display("FAIL rr_ts[%0d] got=%0d want=%0d", k, evt_ts_o, e.ts); end
            total++; if (ack_o !== (4'b0001 << e.id)) begin bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", k, ack_o, 4'b0001 << e.id); end
            // requester model: drop on the cycle after ack, re-raise one cycle later
            req_i = (req_i | prev_ack) & ~ack_o;
            prev_ack = ack_o;
        end
        req_i = 4'b0000;
        tick;
        total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b want=0", evt_valid_o); end
    endtask

    task automatic test_backpressure;
        evt_ready_i = 1'b0; req_i = 4'b0110; timestamp_i = 32'd500;
        sb.push_back('{1, 32'd500});
        tick;
        e = sb.pop_front();
        total++; if (ack_o !== 4'b0010) begin bad++; $display("FAIL bp_ack got=%b want=0010", ack_o); end
        req_i = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            total++; if (evt_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", c, evt_valid_o); end
            total++; if (evt_id_o !== 2'(e.id)) begin bad++; $display("FAIL bp_id[%0d] got=%0d want=%0d", c, evt_id_o, e.id); end
            total++; if (evt_ts_o !== e.ts) begin bad++; $display("FAIL bp_ts[%0d] got=%0d want=%0d", c, evt_ts_o, e.ts); end
            if (c > 0) begin
                total++; if (ack_o !== 4'b0000) begin bad++; $display("FAIL bp_noack[%0d] got=%b want=0000", c, ack_o); end
            end
            if (c < 4) begin
                timestamp_i = timestamp_i + 32'd7;
                tick;
            end
        end
        evt_ready_i = 1'b1;
        sb.push_back('{2, timestamp_i});
        tick;
        e = sb.pop_front();
        total++; if (evt_id_o !== 2'(e.id)) begin bad++; $display("FAIL bp_next_id got=%0d want=%0d", evt_id_o, e.id); end
        total++; if (evt_ts_o !== e.ts) begin bad++; $display("FAIL bp_next_ts got=%0d want=%0d", evt_ts_o, e.ts); end
        total++; if (ack_o !== 4'b0100) begin bad++; $display("FAIL bp_next_ack got=%b want=0100", ack_o); end
        req_i = 4'b0000;
        tick;
        total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b want=0", evt_valid_o); end
    endtask

    task automatic test_enable;
        enable_i = 1'b0; req_i = 4'b1000; timestamp_i = 32'd690;
        for (int c = 0; c < 3; c++) begin
            tick;
            total++; if (evt_valid_o !== 1'b0 || ack_o !== 4'b0000) begin bad++; $display("FAIL en_block[%0d] got valid=%b ack=%b want 0/0000", c, evt_valid_o, ack_o); end
        end
        enable_i = 1'b1; timestamp_i = 32'd700;
        sb.push_back('{3, 32'd700});
        tick;
        e = sb.pop_front();
        total++; if (evt_id_o !== 2'(e.id)) begin bad++; $display("FAIL en_id got=%0d want=%0d", evt_id_o, e.id); end
        total++; if (evt_ts_o !== e.ts) begin bad++; $display("FAIL en_ts got=%0d want=%0d", evt_ts_o, e.ts); end
        total++; if (ack_o !== 4'b1000) begin bad++; $display("FAIL en_ack got=%b want=1000", ack_o); end
        req_i = 4'b0000; evt_ready_i = 1'b0; enable_i = 1'b0;
        tick;
        total++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'(e.id)) begin bad++; $display("FAIL en_hold got valid=%b id=%0d want 1/%0d", evt_valid_o, evt_id_o, e.id); end
        evt_ready_i = 1'b1;
        tick;
        total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL en_complete got=%b want=0", evt_valid_o); end
        enable_i = 1'b1;
    endtask

    task automatic test_wrap;
        timestamp_i = 32'hFFFF_FFFE; #1;
        total++; if (ts_wrap_o !== 1'b0) begin bad++; $display("FAIL wrap_fffe got=%b want=0", ts_wrap_o); end
        tick;
        timestamp_i = 32'hFFFF_FFFF; #1;
        total++; if (ts_wrap_o !== 1'b0) begin bad++; $display("FAIL wrap_ffff got=%b want=0", ts_wrap_o); end
        tick;
        timestamp_i = 32'h0000_0000; #1;
        total++; if (ts_wrap_o !== 1'b1) begin bad++; $display("FAIL wrap_zero got=%b want=1", ts_wrap_o); end
        tick;
        timestamp_i = 32'h0000_0001; #1;
        total++; if (ts_wrap_o !== 1'b0) begin bad++; $display("FAIL wrap_after got=%b want=0", ts_wrap_o); end
        tick;
    endtask

    task automatic test_reset_mid_send;
        evt_ready_i = 1'b0; req_i = 4'b0100; timestamp_i = 32'd900;
        sb.push_back('{2, 32'd900});
        tick;
        e = sb.pop_front();
        total++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'(e.id)) begin bad++; $display("FAIL rst_send got valid=%b id=%0d want 1/%0d", evt_valid_o, evt_id_o, e.id); end
        reset_i = 1'b0; req_i = 4'b0000;
        tick;
        total++; if (evt_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_abort got valid=%b busy=%b want 0/0", evt_valid_o, busy_o); end
        total++; if (evt_id_o !== 2'd0 || evt_ts_o !== 32'd0) begin bad++; $display("FAIL rst_clear got id=%0d ts=%0d want 0/0", evt_id_o, evt_ts_o); end
        reset_i = 1'b1; evt_ready_i = 1'b1; req_i = 4'b1111; timestamp_i = 32'd950;
        sb.push_back('{0, 32'd950});
        tick;
        e = sb.pop_front();
        total++; if (evt_id_o !== 2'(e.id)) begin bad++; $display("FAIL rst_first_id got=%0d want=%0d", evt_id_o, e.id); end
        total++; if (ack_o !== 4'b0001) begin bad++; $display("FAIL rst_first_ack got=%b want=0001", ack_o); end
        total++; if (evt_ts_o !== e.ts) begin bad++; $display("FAIL rst_first_ts got=%0d want=%0d", evt_ts_o, e.ts); end
        req_i = 4'b0000;
        tick;
        total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b want=0", evt_valid_o); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_backpressure;
        test_enable;
        test_wrap;
        test_reset_mid_send;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
